// File: rtl/partial_case_checker.sv
// Response checker for the partial-case mux/latch block: strobed reference model with latch hold,
// mismatch counting and first-failure capture. Optional macro PCC_HALT_ON_ERR_EN ends a run on the first mismatch.
module partial_case_checker #(
   parameter int unsigned NUM_SAMPLES = 64,
   parameter int unsigned CNT_W       = 8,
   parameter int unsigned IDX_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sample_stb,
   input  logic [1:0]       sel,
   input  logic             i0,
   input  logic             i1,
   input  logic             i2,
   input  logic             x,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_cnt,
   output logic [IDX_W-1:0] sample_cnt,
   output logic             first_err_valid,
   output logic [IDX_W-1:0] first_err_idx,
   output logic [1:0]       first_err_sel
);

   // One extra bit so the terminal count is reachable even when NUM_SAMPLES == 2**IDX_W
   localparam int unsigned SC_W = IDX_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [SC_W-1:0]  sample_cnt_q, sample_cnt_d;
   logic             fe_valid_q, fe_valid_d;
   logic [IDX_W-1:0] fe_idx_q, fe_idx_d;
   logic [1:0]       fe_sel_q, fe_sel_d;
   logic             xm_q, xm_d;
   logic             ym_q, ym_d;

   logic             ex, ey;
   logic             mismatch;
   logic [SC_W-1:0]  cnt_inc;

   // Reference model: sel 01/11 hold the previous model output on x, sel 11 also on y
   always_comb begin
      ex = xm_q;
      ey = ym_q;
      case (sel)
         2'b00: begin
            ex = i2;
            ey = i0;
         end
         2'b01: ey = i1;
         2'b10: begin
            ex = i1;
            ey = i2;
         end
         default: ;
      endcase
      mismatch = (x != ex) | (y != ey);
      cnt_inc  = sample_cnt_q + SC_W'(1);
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      err_cnt_d    = err_cnt_q;
      sample_cnt_d = sample_cnt_q;
      fe_valid_d   = fe_valid_q;
      fe_idx_d     = fe_idx_q;
      fe_sel_d     = fe_sel_q;
      xm_d         = xm_q;
      ym_d         = ym_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_RUN;
               err_cnt_d    = '0;
               sample_cnt_d = '0;
               fe_valid_d   = 1'b0;
               fe_idx_d     = '0;
               fe_sel_d     = 2'b00;
               xm_d         = 1'b0;
               ym_d         = 1'b0;
            end
         end
         S_RUN: begin
            if (sample_stb) begin
               sample_cnt_d = cnt_inc;
               xm_d         = ex;
               ym_d         = ey;
               if (mismatch) begin
                  if (err_cnt_q != {CNT_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + CNT_W'(1);
                  end
                  if (!fe_valid_q) begin
                     fe_valid_d = 1'b1;
                     fe_idx_d   = sample_cnt_q[IDX_W-1:0];
                     fe_sel_d   = sel;
                  end
               end
               if (cnt_inc == SC_W'(NUM_SAMPLES)) begin
                  state_d = S_DONE;
               end
`ifdef PCC_HALT_ON_ERR_EN
               if (mismatch) begin
                  state_d = S_DONE;
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_cnt_d == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_cnt_q    <= '0;
         sample_cnt_q <= '0;
         fe_valid_q   <= 1'b0;
         fe_idx_q     <= '0;
         fe_sel_q     <= 2'b00;
         xm_q         <= 1'b0;
         ym_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_cnt_q    <= err_cnt_d;
         sample_cnt_q <= sample_cnt_d;
         fe_valid_q   <= fe_valid_d;
         fe_idx_q     <= fe_idx_d;
         fe_sel_q     <= fe_sel_d;
         xm_q         <= xm_d;
         ym_q         <= ym_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign pass            = pass_q;
   assign err_cnt         = err_cnt_q;
   assign sample_cnt      = sample_cnt_q[IDX_W-1:0];
   assign first_err_valid = fe_valid_q;
   assign first_err_idx   = fe_idx_q;
   assign first_err_sel   = fe_sel_q;

endmodule

// File: tb/tb_partial_case_checker.sv
// Bench for partial_case_checker: two instances (4 samples / 8-bit count, 6 samples / 2-bit count)
// share the stimulus bus; run results are scoreboarded when done rises.
module tb_partial_case_checker;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_a, start_b, sample_stb;
   logic [1:0] sel;
   logic       i0, i1, i2, x, y;

   logic       busy_a, done_a, pass_a, fev_a;
   logic [7:0] err_a, cnt_a, fei_a;
   logic [1:0] fes_a;
   logic       busy_b, done_b, pass_b, fev_b;
   logic [1:0] err_b;
   logic [7:0] cnt_b, fei_b;
   logic [1:0] fes_b;

   partial_case_checker #(.NUM_SAMPLES(4), .CNT_W(8), .IDX_W(8)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .sample_stb(sample_stb),
      .sel(sel), .i0(i0), .i1(i1), .i2(i2), .x(x), .y(y),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
      .sample_cnt(cnt_a), .first_err_valid(fev_a), .first_err_idx(fei_a),
      .first_err_sel(fes_a)
   );

   partial_case_checker #(.NUM_SAMPLES(6), .CNT_W(2), .IDX_W(8)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .sample_stb(sample_stb),
      .sel(sel), .i0(i0), .i1(i1), .i2(i2), .x(x), .y(y),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
      .sample_cnt(cnt_b), .first_err_valid(fev_b), .first_err_idx(fei_b),
      .first_err_sel(fes_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pass;
      logic [31:0] err;
      logic [31:0] cnt;
      logic [31:0] fev;
      logic [31:0] fei;
      logic [31:0] fes;
   } exp_t;

   typedef struct packed {
      logic [1:0] sel;
      logic       i0, i1, i2, x, y, st;
   } vec_t;

   exp_t q_a[$];
   exp_t q_b[$];
   vec_t vq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk_exp(int p, int e, int c, int v, int fi, int fs);
      exp_t r;
      r.pass = 32'(p); r.err = 32'(e); r.cnt = 32'(c);
      r.fev  = 32'(v); r.fei = 32'(fi); r.fes = 32'(fs);
      return r;
   endfunction

   function automatic vec_t mk(logic [1:0] s, logic a0, logic a1, logic a2,
                               logic ax, logic ay, logic st);
      vec_t v;
      v.sel = s; v.i0 = a0; v.i1 = a1; v.i2 = a2; v.x = ax; v.y = ay; v.st = st;
      return v;
   endfunction

   // Scoreboard monitor: pop and compare a run result on each rising done
   logic done_a_prev = 1'b0;
   logic done_b_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset && done_a && !done_a_prev) begin
         if (q_a.size() == 0) chk("a_unexpected_done", 1, 0);
         else begin
            e = q_a.pop_front();
            chk("a_pass", 32'(pass_a), e.pass);
            chk("a_err_cnt", 32'(err_a), e.err);
            chk("a_sample_cnt", 32'(cnt_a), e.cnt);
            chk("a_fe_valid", 32'(fev_a), e.fev);
            chk("a_fe_idx", 32'(fei_a), e.fei);
            chk("a_fe_sel", 32'(fes_a), e.fes);
         end
      end
      if (!reset && done_b && !done_b_prev) begin
         if (q_b.size() == 0) chk("b_unexpected_done", 1, 0);
         else begin
            e = q_b.pop_front();
            chk("b_pass", 32'(pass_b), e.pass);
            chk("b_err_cnt", 32'(err_b), e.err);
            chk("b_sample_cnt", 32'(cnt_b), e.cnt);
            chk("b_fe_valid", 32'(fev_b), e.fev);
            chk("b_fe_idx", 32'(fei_b), e.fei);
            chk("b_fe_sel", 32'(fes_b), e.fes);
         end
      end
      done_a_prev = done_a;
      done_b_prev = done_b;
   end

   task automatic drive(input vec_t v);
      sel = v.sel; i0 = v.i0; i1 = v.i1; i2 = v.i2; x = v.x; y = v.y;
   endtask

   task automatic do_start(input bit on_b, input bit with_stb, input vec_t v);
      @(negedge clk);
      drive(v);
      start_a    = !on_b;
      start_b    = on_b;
      sample_stb = with_stb;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0; sample_stb = 1'b0;
   endtask

   // Back-to-back strobes from vq; optionally check A's progress between strobes
   task automatic apply_vecs(input bit prog);
      for (int k = 0; k < vq.size(); k++) begin
         @(negedge clk);
         if (prog && k > 0) begin
            chk($sformatf("a_cnt_lag_%0d", k), 32'(cnt_a), 32'(k));
            chk($sformatf("a_done_early_%0d", k), 32'(done_a), 0);
         end
         drive(vq[k]);
         start_a    = vq[k].st;
         sample_stb = 1'b1;
      end
      @(negedge clk);
      sample_stb = 1'b0;
      start_a    = 1'b0;
   endtask

   task automatic check_a_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy_a), 0);
      chk({tag, "_done"}, 32'(done_a), 0);
      chk({tag, "_pass"}, 32'(pass_a), 0);
      chk({tag, "_err"}, 32'(err_a), 0);
      chk({tag, "_cnt"}, 32'(cnt_a), 0);
      chk({tag, "_fev"}, 32'(fev_a), 0);
      chk({tag, "_fei"}, 32'(fei_a), 0);
      chk({tag, "_fes"}, 32'(fes_a), 0);
   endtask

   task automatic load_clean(input bit mid_start);
      vq.delete();
      vq.push_back(mk(2'b00, 1, 0, 1, 1, 1, 0));
      vq.push_back(mk(2'b01, 1, 0, 1, 1, 0, mid_start));
      vq.push_back(mk(2'b10, 1, 0, 1, 0, 1, 0));
      vq.push_back(mk(2'b11, 1, 0, 1, 0, 1, 0));
   endtask

   initial begin
      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0; sample_stb = 1'b0;
      drive(mk(2'b00, 0, 0, 0, 0, 0, 0));

      // Reset held, then strobes without start
      repeat (10) @(negedge clk);
      check_a_zero("rst_a");
      chk("rst_b_err", 32'(err_b), 0);
      chk("rst_b_cnt", 32'(cnt_b), 0);
      reset = 1'b0;
      vq.delete();
      for (int k = 0; k < 3; k++) vq.push_back(mk(2'b00, 1, 1, 1, 0, 0, 0));
      apply_vecs(1'b0);
      chk("idle_stb_cnt_a", 32'(cnt_a), 0);
      chk("idle_stb_done_a", 32'(done_a), 0);
      chk("idle_stb_busy_a", 32'(busy_a), 0);
      chk("idle_stb_cnt_b", 32'(cnt_b), 0);

      // Clean run; start pulse mid-run must be ignored
      do_start(1'b0, 1'b0, mk(2'b00, 0, 0, 0, 0, 0, 0));
      chk("run_busy_a", 32'(busy_a), 1);
      chk("run_cnt0_a", 32'(cnt_a), 0);
      q_a.push_back(mk_exp(1, 0, 4, 0, 0, 0));
      load_clean(1'b1);
      apply_vecs(1'b1);
      chk("clean_done", 32'(done_a), 1);
      chk("clean_busy", 32'(busy_a), 0);
      chk("clean_pass", 32'(pass_a), 1);
      chk("clean_cnt", 32'(cnt_a), 4);

      // Latch hold mismatch at idx 1; the start-coincident strobe is not checked
      do_start(1'b0, 1'b1, mk(2'b00, 1, 0, 0, 0, 0, 0));
      chk("start_stb_cnt", 32'(cnt_a), 0);
      chk("start_stb_err", 32'(err_a), 0);
      chk("start_stb_busy", 32'(busy_a), 1);
`ifdef PCC_HALT_ON_ERR_EN
      q_a.push_back(mk_exp(0, 1, 2, 1, 1, 1));
`else
      q_a.push_back(mk_exp(0, 1, 4, 1, 1, 1));
`endif
      vq.delete();
      vq.push_back(mk(2'b00, 0, 0, 1, 1, 0, 0));
      vq.push_back(mk(2'b01, 0, 1, 0, 0, 1, 0));
      vq.push_back(mk(2'b10, 0, 1, 0, 1, 0, 0));
      vq.push_back(mk(2'b11, 0, 1, 0, 1, 0, 0));
      apply_vecs(1'b0);
      chk("hold_done", 32'(done_a), 1);
      chk("hold_pass", 32'(pass_a), 0);
      chk("hold_err", 32'(err_a), 1);
      chk("hold_fei", 32'(fei_a), 1);
      chk("hold_fes", 32'(fes_a), 1);
`ifdef PCC_HALT_ON_ERR_EN
      chk("hold_cnt", 32'(cnt_a), 2);
`else
      chk("hold_cnt", 32'(cnt_a), 4);
`endif

      // Saturation on the 2-bit instance: every sample mismatches
      do_start(1'b1, 1'b0, mk(2'b00, 0, 0, 0, 0, 0, 0));
      chk("sat_busy_b", 32'(busy_b), 1);
`ifdef PCC_HALT_ON_ERR_EN
      q_b.push_back(mk_exp(0, 1, 1, 1, 0, 0));
`else
      q_b.push_back(mk_exp(0, 3, 6, 1, 0, 0));
`endif
      vq.delete();
      for (int k = 0; k < 6; k++) vq.push_back(mk(2'b00, 0, 0, 1, 0, 0, 0));
      apply_vecs(1'b0);
      chk("sat_done_b", 32'(done_b), 1);
      chk("sat_pass_b", 32'(pass_b), 0);
`ifdef PCC_HALT_ON_ERR_EN
      chk("sat_err_b", 32'(err_b), 1);
      chk("a_ignored_cnt", 32'(cnt_a), 2);
`else
      chk("sat_err_b", 32'(err_b), 3);
      chk("a_ignored_cnt", 32'(cnt_a), 4);
`endif
      chk("a_ignored_err", 32'(err_a), 1);

      // Reset mid-run, then a clean run
      do_start(1'b0, 1'b0, mk(2'b00, 0, 0, 0, 0, 0, 0));
      load_clean(1'b0);
      vq = vq[0:1];
      apply_vecs(1'b0);
      chk("mid_cnt_before_rst", 32'(cnt_a), 2);
      #2 reset = 1'b1;
      #1;
      check_a_zero("async_rst_a");
      chk("async_rst_b_done", 32'(done_b), 0);
      @(negedge clk);
      reset = 1'b0;
      do_start(1'b0, 1'b0, mk(2'b00, 0, 0, 0, 0, 0, 0));
      q_a.push_back(mk_exp(1, 0, 4, 0, 0, 0));
      load_clean(1'b0);
      apply_vecs(1'b1);
      chk("rerun_pass", 32'(pass_a), 1);
      chk("rerun_done", 32'(done_a), 1);

      repeat (3) @(negedge clk);
      chk("q_a_drained", 32'(q_a.size()), 0);
      chk("q_b_drained", 32'(q_b.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
